// File: rtl/regfile_sb.sv
// Two-read/one-write register file with per-register busy scoreboard and a
// post-reset / on-request clear sweep. Optional same-cycle bypass: REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              ready,
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [DATA_W-1:0] writeData,
  input  logic              WE,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              busy1,
  output logic              busy2
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_ok, rsv_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  // Register 0 is hard-wired when ZERO_REG is set: never written, never reserved.
  assign wr_ok  = WE     && !((ZERO_REG != 0) && (writeRegister == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_reg == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    unique case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        busy_d    = '0;
        if (clr_idx_q == '1) state_d = READY;
      end
      READY: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          busy_d    = '0;
        end else begin
          // Release first so a same-edge reservation of the same register wins.
          if (wr_ok)  busy_d[writeRegister] = 1'b0;
          if (rsv_ok) busy_d[rsv_reg]       = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    ready = (state_q == READY);
  end

  // Single write port shared by the sweep and the write-back path.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = writeRegister;
    mem_wd = writeData;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_idx_q;
      mem_wd = '0;
    end else begin
      mem_we = wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             rbusy;

  assign raddr = {readRegister2, readRegister1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero_hit, byp_hit;
    assign zero_hit = (ZERO_REG != 0) && (raddr[p] == '0);
`ifdef REGFILE_BYPASS_EN
    assign byp_hit  = wr_ok && (writeRegister == raddr[p]);
`else
    assign byp_hit  = 1'b0;
`endif
    assign rdata[p] = (!ready || zero_hit) ? '0
                    : (byp_hit ? writeData : mem_q[raddr[p]]);
    assign rbusy[p] = ready && !zero_hit && !byp_hit && busy_q[raddr[p]];
  end

  assign readData1 = rdata[0];
  assign readData2 = rdata[1];
  assign busy1     = rbusy[0];
  assign busy2     = rbusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep timing, read/write, scoreboard, clear, reset mid-sweep.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b1, clear_req = 1'b0, ready;
  logic        WE = 1'b0, rsv_en = 1'b0, busy1, busy2;
  logic [4:0]  readRegister1 = '0, readRegister2 = '0, writeRegister = '0, rsv_reg = '0;
  logic [31:0] readData1, readData2, writeData = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2),
    .writeRegister(writeRegister), .writeData(writeData), .WE(WE),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(busy1), .busy2(busy2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  rr;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
    logic        b1, b2;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    WE = 1'b0; rsv_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic sweep_chk(input string nm);
    for (int i = 1; i <= 32; i++) begin
      step();
      chk(nm, i, {31'b0, ready}, {31'b0, (i == 32)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[3] = '{1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 5'd9, 5'd5, BYP ? 32'h11 : 32'h0, 32'hDEADBEEF, !BYP, 1'b0};
    vt[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h11, 32'h11, 1'b1, 1'b1};
    vt[5] = '{1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 5'd9, 5'd5, BYP ? 32'h22 : 32'h11, 32'hDEADBEEF, !BYP, 1'b0};
    vt[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0, 32'h22, 32'h0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h22, 1'b0, 1'b0};
    vt[8] = '{1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 5'd7, 5'd0, BYP ? 32'hCAFEF00D : 32'h0, 32'h0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0};

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 0, {31'b0, ready}, 32'h0);
    chk("rst_busy", 0, {30'b0, busy1, busy2}, 32'h0);
    chk("rst_rd1", 0, readData1, 32'h0);
    chk("rst_rd2", 0, readData2, 32'h0);
    #19 rst_n = 1'b1;
    sweep_chk("sweep0");

    // Fill with garbage, then reset and expect a clean file
    for (int i = 0; i < 32; i++) begin
      WE = 1'b1; writeRegister = 5'(i); writeData = 32'hA5A50000 | 32'(i);
      step();
    end
    idle();
    readRegister1 = 5'd17;
    #1 chk("garbage_r17", 0, readData1, 32'hA5A50011);
    rst_n = 1'b0;
    #1 chk("rst2_ready", 0, {31'b0, ready}, 32'h0);
    chk("rst2_rd1", 0, readData1, 32'h0);
    #10 rst_n = 1'b1;
    sweep_chk("sweep1");
    for (int i = 0; i < 32; i++) begin
      readRegister1 = 5'(i); readRegister2 = 5'(31 - i);
      #1;
      chk("zero_rd1", i, readData1, 32'h0);
      chk("zero_rd2", i, readData2, 32'h0);
    end

    // Table-driven read/write/scoreboard/bypass vectors
    for (int v = 0; v < 10; v++) begin
      WE = vt[v].we; writeRegister = vt[v].wr; writeData = vt[v].wd;
      rsv_en = vt[v].rsv; rsv_reg = vt[v].rr;
      readRegister1 = vt[v].a1; readRegister2 = vt[v].a2;
      #1;
      chk("vec_ready", v, {31'b0, ready}, 32'h1);
      chk("vec_rd1", v, readData1, vt[v].e1);
      chk("vec_rd2", v, readData2, vt[v].e2);
      chk("vec_busy1", v, {31'b0, busy1}, {31'b0, vt[v].b1});
      chk("vec_busy2", v, {31'b0, busy2}, {31'b0, vt[v].b2});
      step();
    end
    idle();

    // clear_req with r3 holding data and reserved
    WE = 1'b1; writeRegister = 5'd3; writeData = 32'h55; rsv_en = 1'b1; rsv_reg = 5'd3;
    step();
    idle();
    readRegister1 = 5'd3; readRegister2 = 5'd6;
    #1;
    chk("clr_pre_busy", 0, {31'b0, busy1}, 32'h1);
    chk("clr_pre_rd", 0, readData1, 32'h55);
    clear_req = 1'b1; WE = 1'b1; writeRegister = 5'd4; writeData = 32'h77;
    rsv_en = 1'b1; rsv_reg = 5'd6;
    step();
    chk("clr_ready0", 0, {31'b0, ready}, 32'h0);
    chk("clr_rd_forced", 0, readData1, 32'h0);
    for (int i = 1; i <= 32; i++) begin
      if (i <= 16) begin
        clear_req = 1'b1; WE = 1'b1; writeRegister = 5'd10; writeData = 32'hAA;
        rsv_en = 1'b1; rsv_reg = 5'd11;
      end else begin
        idle();
      end
      step();
      chk("clr_sweep", i, {31'b0, ready}, {31'b0, (i == 32)});
    end
    idle();
    #1;
    chk("clr_r3_rd", 0, readData1, 32'h0);
    chk("clr_r3_busy", 0, {31'b0, busy1}, 32'h0);
    chk("clr_r6_busy", 0, {31'b0, busy2}, 32'h0);
    readRegister1 = 5'd10; readRegister2 = 5'd11;
    #1;
    chk("clr_r10_rd", 0, readData1, 32'h0);
    chk("clr_r11_busy", 0, {31'b0, busy2}, 32'h0);
    readRegister1 = 5'd4;
    #1 chk("clr_r4_rd", 0, readData1, 32'h0);

    // Reset in the middle of a sweep restarts it from index 0
    WE = 1'b1; writeRegister = 5'd20; writeData = 32'h2020;
    step();
    idle();
    readRegister1 = 5'd20;
    #1 chk("mid_pre_r20", 0, readData1, 32'h2020);
    clear_req = 1'b1;
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1 chk("mid_ready", 0, {31'b0, ready}, 32'h0);
    #10 rst_n = 1'b1;
    sweep_chk("sweep2");
    #1 chk("mid_r20", 0, readData1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/one-write register file for the pipelined MIPS core. It adds a per-register scoreboard (busy bits) for hazard detection and a hardware clear sweep that zeroes every entry after reset or on request. It also has optional same-cycle write-to-read bypass. It sits between decode (reads and reservations) and write-back (writes and releases).

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 1 << ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 reads as 0, is never written and is never marked busy
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear_req  in  1  request a full clear sweep (sampled only in READY)
- ready  out  DATA-independent 1  high when the file is usable; low during the sweep
- readRegister1, readRegister2  in  ADDR_W  read addresses
- readData1, readData2  out  DATA_W  combinational read data
- writeRegister  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- WE  in  1  write enable; also releases the scoreboard entry
- rsv_en  in  1  reserve (mark busy) rsv_reg
- rsv_reg  in  ADDR_W  register to reserve
- busy1, busy2  out  1  scoreboard bit for readRegister1/readRegister2 (combinational)

## Operation
- FSM states: CLEAR, READY. Reset enters CLEAR with clr_idx = 0, all busy bits = 0 and ready = 0.
- CLEAR:
  - Each cycle writes 0 to entry clr_idx, then increments clr_idx.
  - When clr_idx = DEPTH-1 (all ones), that entry is written and the next state is READY.
  - clr_idx is ADDR_W bits wide; it wraps to 0 on exit.
  - WE, rsv_en and clear_req are ignored.
  - readData1/2 = 0 and busy1/2 = 0.
- READY:
  - WE with writeRegister != 0 (or any address when ZERO_REG = 0) stores writeData and clears busy[writeRegister].
  - rsv_en sets busy[rsv_reg]. This is ignored for rsv_reg = 0 when ZERO_REG = 1.
  - Simultaneous WE and rsv_en on the same register: data is written and the busy bit ends SET (the new producer wins).
  - clear_req = 1: next state is CLEAR, clr_idx = 0 and all busy bits are cleared at that edge. A WE in that same cycle is still performed; an rsv_en in that cycle is discarded.
- Reads are combinational: readDataN = mem[readRegisterN], or 0 when readRegisterN = 0 and ZERO_REG = 1.
- busyN = busy[readRegisterN], forced to 0 for register 0 when ZERO_REG = 1.
- Storage array is not reset directly; only the sweep clears it. Busy bits and FSM state are reset asynchronously.

## Timing
- Reset values: ready = 0, busy1 = busy2 = 0, readData1 = readData2 = 0.
- After rst_n rises, the sweep takes DEPTH rising edges. ready goes high after the DEPTH-th edge (edge 32 for ADDR_W = 5).
- Reset asserted mid-sweep restarts the sweep from index 0 with ready = 0.
- clear_req in READY at edge N: ready = 0 after edge N and ready = 1 again after edge N+DEPTH.
- Write latency: data written at edge N is visible on reads after edge N (no bypass) or combinationally during cycle N (bypass enabled).
- Scoreboard latency: rsv_en at edge N gives busy = 1 after N. WE at edge M gives busy = 0 after M, unless the same-edge reserve rule applies.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: in READY, if WE = 1 and writeRegister = readRegisterN (and is not a protected register 0), readDataN = writeData combinationally in the same cycle. busyN is also forced to 0 in that case, since the value is being delivered.
- Undefined: reads return stored contents only. A same-cycle write becomes visible the next cycle, and busyN reflects the stored bit.

## Test plan
- Reset sweep: preload garbage via backdoor, pulse rst_n low, then release -> ready = 0 for 32 edges, ready = 1 after edge 32, and all 32 entries read 0.
- Write/read and register 0: write 0xDEADBEEF to r5 and 0x12345678 to r0 -> r5 reads 0xDEADBEEF and r0 reads 0 (ZERO_REG = 1).
- Bypass, with the macro defined: WE to r7 with 0xCAFEF00D and readRegister1 = 7 in the same cycle -> readData1 = 0xCAFEF00D in that cycle. With the macro undefined -> old value in that cycle, new value the next cycle.
- Scoreboard:
  - rsv_en r9 -> busy1 = 1 for readRegister1 = 9.
  - Later, WE r9 together with rsv_en r9 -> busy stays 1.
  - Then WE r9 alone -> busy = 0.
  - rsv_en r0 -> busy stays 0.
- clear_req in READY with r3 = 0x55 and r3 busy -> ready low for 32 cycles, busy cleared immediately, and r3 reads 0 afterwards. A WE or rsv_en during the sweep has no effect.
- Reset mid-sweep: assert rst_n at sweep cycle 10 -> ready stays 0 and a full 32-cycle sweep restarts from index 0 after release.
